// File: rtl/flog_pkg.sv
// flog_pkg: shared types and constants for the iterative log2 unit.
//   flog_state_t      : FSM states of flog_iter
//   S_WIDTH/EXP_WIDTH/FRACT_WIDTH/BIAS : default bfloat16 field widths
//   flog_inf/qnan/zero: special encodings for a given field width
//   FLAG_*            : bit positions inside flags {invalid, div_by_zero, inexact}
package flog_pkg;

  typedef enum logic [2:0] {IDLE, ITER, NORM, SPEC, DONE} flog_state_t;

  localparam int S_WIDTH     = 1;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
  localparam int BIAS        = (1 << (EXP_WIDTH - 1)) - 1;

  localparam int FLAG_NX = 0;
  localparam int FLAG_DZ = 1;
  localparam int FLAG_NV = 2;

  // Encodings are built in a 64-bit word; callers cut them to their width.
  function automatic logic [63:0] flog_inf(input int ew, input int fw, input logic sgn);
    return (64'(sgn) << (ew + fw)) | (((64'd1 << ew) - 64'd1) << fw);
  endfunction

  function automatic logic [63:0] flog_qnan(input int ew, input int fw);
    return flog_inf(ew, fw, 1'b0) | (64'd1 << (fw - 1));
  endfunction

  function automatic logic [63:0] flog_zero(input int ew, input int fw, input logic sgn);
    return 64'(sgn) << (ew + fw);
  endfunction

endpackage

// File: rtl/flog_lzc.sv
// flog_lzc: leading-zero counter.
//   data : input word
//   cnt  : number of leading zeros (WIDTH when data is all-zero)
//   zero : data is all-zero
module flog_lzc #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0]             data,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         zero
);
  localparam int CW = $clog2(WIDTH + 1);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (data[i]) cnt = CW'(WIDTH - 1 - i);
  end

  assign zero = ~|data;
endmodule

// File: rtl/flog_iter.sv
// flog_iter: iterative log2 for IEEE-style floats, one operation in flight.
//   clk_i, rst_ni           : clock, async active-low reset
//   in_valid_i / in_ready_o : operand handshake, op_i = {sign, exp, fract}
//   out_valid_o/out_ready_i : result handshake, res_o in the operand format
//   flags_o                 : {invalid, div_by_zero, inexact}
// Build option: FLOG_RNE_EN selects round-to-nearest-even in NORM;
// without it the result is truncated toward zero.
module flog_iter #(
  parameter int EXP_WIDTH   = flog_pkg::EXP_WIDTH,
  parameter int FRACT_WIDTH = flog_pkg::FRACT_WIDTH,
  parameter int ITER_BITS   = FRACT_WIDTH + 4,
  parameter int WORK_WIDTH  = FRACT_WIDTH + 8,
  parameter int BIAS        = (1 << (EXP_WIDTH - 1)) - 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [EXP_WIDTH+FRACT_WIDTH:0]   op_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [EXP_WIDTH+FRACT_WIDTH:0]   res_o,
  output logic [2:0]                       flags_o
);
  import flog_pkg::*;

  localparam int W   = 1 + EXP_WIDTH + FRACT_WIDTH;
  localparam int KW  = EXP_WIDTH + 1;          // signed unbiased exponent
  localparam int LW  = KW + ITER_BITS;         // fixed-point log word {k, F}
  localparam int YW  = WORK_WIDTH + 1;         // y in Q1.WORK_WIDTH
  localparam int PW  = 2 * YW;                 // y*y in Q2.2W
  localparam int CW  = $clog2(ITER_BITS + 1);
  localparam int LZW = $clog2(LW + 1);
  localparam int DW  = LW - 1 - FRACT_WIDTH;   // bits dropped below the mantissa
  localparam int XW  = EXP_WIDTH + 2;          // headroom for exponent overflow

  localparam logic [W-1:0] QNAN  = W'(flog_qnan(EXP_WIDTH, FRACT_WIDTH));
  localparam logic [W-1:0] PINF  = W'(flog_inf(EXP_WIDTH, FRACT_WIDTH, 1'b0));
  localparam logic [W-1:0] NINF  = W'(flog_inf(EXP_WIDTH, FRACT_WIDTH, 1'b1));
  localparam logic [W-1:0] PZERO = W'(flog_zero(EXP_WIDTH, FRACT_WIDTH, 1'b0));

  flog_state_t             state;
  logic [YW-1:0]           y;
  logic [KW-1:0]           k;
  logic [ITER_BITS-1:0]    f;
  logic [CW-1:0]           cnt;
  logic                    nx;
  logic [W-1:0]            res_q;
  logic [2:0]              flags_q;

  // operand decode
  logic                    op_s, e_max, e_zero, is_nan, special;
  logic [EXP_WIDTH-1:0]    op_e;
  logic [FRACT_WIDTH-1:0]  op_m;
  logic [W-1:0]            spec_res;
  logic [2:0]              spec_flg;

  assign op_s    = op_i[W-1];
  assign op_e    = op_i[W-2 -: EXP_WIDTH];
  assign op_m    = op_i[FRACT_WIDTH-1:0];
  assign e_max   = &op_e;
  assign e_zero  = ~|op_e;
  assign is_nan  = e_max & (|op_m);
  // Denormals flush to zero, so every E=0 operand is special.
  assign special = e_max | e_zero | op_s;

  always_comb begin
    spec_res = PINF;
    spec_flg = '0;
    if (is_nan) begin
      spec_res = QNAN;
      spec_flg[FLAG_NV] = ~op_m[FRACT_WIDTH-1];
    end else if (e_zero) begin
      spec_res = NINF;
      spec_flg[FLAG_DZ] = 1'b1;
    end else if (op_s) begin
      spec_res = QNAN;
      spec_flg[FLAG_NV] = 1'b1;
    end
  end

  // one Philo step: square, emit a bit, renormalise y into [1,2)
  logic [PW-1:0]           prod;
  logic [WORK_WIDTH+1:0]   y2;
  logic [YW-1:0]           y_nxt;
  logic                    bit_nxt, lost;

  assign prod    = PW'(y) * PW'(y);
  assign y2      = prod[PW-1:WORK_WIDTH];
  assign bit_nxt = y2[WORK_WIDTH+1];
  assign y_nxt   = bit_nxt ? y2[WORK_WIDTH+1:1] : y2[WORK_WIDTH:0];
  assign lost    = (|prod[WORK_WIDTH-1:0]) | (bit_nxt & y2[0]);

  // normalise {k, F} into sign / exponent / mantissa
  logic [LW-1:0]           lval, mag;
  logic [LW-2:0]           norm;
  logic [LZW-1:0]          lz;
  logic                    neg, lzero, ovf;
  logic [FRACT_WIDTH-1:0]  mant, mant_f;
  logic [DW-1:0]           disc;
  logic [XW-1:0]           rexp, exp_f;
  logic [W-1:0]            norm_res;
  logic [2:0]              norm_flg;

  assign lval = {k, f};
  assign neg  = lval[LW-1];
  assign mag  = neg ? -lval : lval;

  flog_lzc #(.WIDTH(LW)) u_lzc (.data(mag), .cnt(lz), .zero(lzero));

  // Leading one lands in the dropped top bit; it is the hidden bit.
  assign norm = (LW-1)'(mag << lz);
  assign mant = norm[LW-2 -: FRACT_WIDTH];
  assign disc = norm[DW-1:0];
  assign rexp = XW'(BIAS + EXP_WIDTH) - XW'(lz);

`ifdef FLOG_RNE_EN
  logic                    rnd_up;
  logic [FRACT_WIDTH:0]    mant_r;
  assign rnd_up = disc[DW-1] & ((|disc[DW-2:0]) | mant[0]);
  assign mant_r = {1'b0, mant} + (FRACT_WIDTH+1)'(rnd_up);
  assign mant_f = mant_r[FRACT_WIDTH-1:0];
  assign exp_f  = rexp + XW'(mant_r[FRACT_WIDTH]);
`else
  assign mant_f = mant;
  assign exp_f  = rexp;
`endif

  assign ovf = exp_f >= XW'((1 << EXP_WIDTH) - 1);

  always_comb begin
    norm_flg = '0;
    norm_flg[FLAG_NX] = nx | (|disc);
    if (lzero)    norm_res = PZERO;
    else if (ovf) norm_res = neg ? NINF : PINF;
    else          norm_res = {neg, exp_f[EXP_WIDTH-1:0], mant_f};
  end

  // The special result is resolved at accept; SPEC only sets its latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      y       <= '0;
      k       <= '0;
      f       <= '0;
      cnt     <= '0;
      nx      <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          if (special) begin
            state   <= SPEC;
            res_q   <= spec_res;
            flags_q <= spec_flg;
          end else begin
            state <= ITER;
            y     <= {1'b1, op_m, {(WORK_WIDTH-FRACT_WIDTH){1'b0}}};
            k     <= {1'b0, op_e} - KW'(BIAS);
            f     <= '0;
            cnt   <= '0;
            nx    <= 1'b0;
          end
        end
        ITER: begin
          y   <= y_nxt;
          f   <= {f[ITER_BITS-2:0], bit_nxt};
          nx  <= nx | lost;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER_BITS - 1)) state <= NORM;
        end
        NORM: begin
          res_q   <= norm_res;
          flags_q <= norm_flg;
          state   <= DONE;
        end
        SPEC: state <= DONE;
        DONE: if (out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so the unit never advertises ready while held in reset.
  assign in_ready_o  = rst_ni & (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign res_o       = res_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_flog_iter.sv
// tb_flog_iter: directed and randomized checks of flog_iter (default bfloat16
// widths) against a value-level log2 model.
module tb_flog_iter;

  logic        clk_i, rst_ni, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [15:0] op_i, res_o;
  logic [2:0]  flags_o;

  int tests = 0;
  int errs  = 0;

  flog_iter u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .res_o(res_o), .flags_o(flags_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // log2 model: Philo bits from squaring in plain integers, then the
  // value {k,F} is rounded onto a 7-bit mantissa by magnitude arithmetic.
  function automatic void ref_log2(input logic [15:0] op, output logic [15:0] r,
                                   output logic [2:0] fl, output bit spec);
    int e = int'(op[14:7]);
    int m = int'(op[6:0]);
    longint y, sq, t, l, mag, rem, half;
    int fb, p, mant, ex;
    bit nx, neg;
    spec = 1'b1;
    fl   = 3'b000;
    r    = 16'h0000;
    if (e == 255 && m != 0) begin
      r = 16'h7FC0; fl[2] = ~op[6];
    end else if (e == 0) begin
      r = 16'hFF80; fl[1] = 1'b1;
    end else if (op[15]) begin
      r = 16'h7FC0; fl[2] = 1'b1;
    end else if (e == 255) begin
      r = 16'h7F80;
    end else begin
      spec = 1'b0;
      y  = longint'(128 + m) << 8;     // 1.m scaled by 2^15
      fb = 0;
      nx = 1'b0;
      for (int i = 0; i < 11; i++) begin
        sq = y * y;                    // scaled by 2^30
        t  = sq >> 15;
        if (sq % 32768 != 0) nx = 1'b1;
        fb = fb * 2;
        if (t >= 65536) begin
          fb = fb + 1;
          if (t % 2 != 0) nx = 1'b1;
          y = t / 2;
        end else y = t;
      end
      l = longint'(e - 127) * 2048 + longint'(fb);
      if (l == 0) begin
        r = 16'h0000; fl[0] = nx;
      end else begin
        neg = (l < 0);
        mag = neg ? -l : l;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p >= 7) begin
          mant = int'((mag >> (p - 7)) % 128);
          rem  = mag % (longint'(1) << (p - 7));
          half = (p >= 8) ? (longint'(1) << (p - 8)) : 0;
        end else begin
          mant = int'((mag << (7 - p)) % 128);
          rem  = 0;
          half = 0;
        end
        ex = 127 + p - 11;
`ifdef FLOG_RNE_EN
        if (rem != 0 && (rem > half || (rem == half && mant % 2 == 1))) mant++;
        if (mant == 128) begin mant = 0; ex++; end
`endif
        if (rem != 0) nx = 1'b1;
        r  = {neg, 8'(ex), 7'(mant)};
        fl = {2'b00, nx};
      end
    end
  endfunction

  // Issue one operand, check latency/result/flags, optionally stall the
  // consumer while a second operand is pending on the input.
  task automatic run_op(input string tag, input logic [15:0] op, input logic [15:0] eres,
                        input logic [2:0] efl, input int elat, input int stall);
    int n = 0;
    while (!in_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    chk({tag, ":rdy"}, 32'(in_ready_o), 32'd1);
    out_ready_i = (stall == 0);
    in_valid_i  = 1'b1;
    op_i        = op;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 1;
    while (!out_valid_o && n < 100) begin @(posedge clk_i); #1; n++; end
    chk({tag, ":lat"}, 32'(n), 32'(elat));
    chk({tag, ":res"}, 32'(res_o), 32'(eres));
    chk({tag, ":flg"}, 32'(flags_o), 32'(efl));
    if (stall > 0) begin
      in_valid_i = 1'b1;
      op_i       = 16'h4000;
      repeat (stall) begin
        @(posedge clk_i); #1;
        chk({tag, ":hold"}, {13'd0, out_valid_o, in_ready_o, 1'b0, res_o},
            {13'd0, 1'b1, 1'b0, 1'b0, eres});
      end
      out_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk({tag, ":drain"}, {30'd0, out_valid_o, in_ready_o}, 32'd1);
  endtask

  initial begin
    logic [15:0] op, r;
    logic [2:0]  fl;
    bit          sp;

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; op_i = '0;
    repeat (2) @(posedge clk_i); #1;
    chk("reset", {10'd0, in_ready_o, out_valid_o, 1'b0, flags_o, res_o}, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", 32'(in_ready_o), 32'd1);

    // directed values
    run_op("one",   16'h3F80, 16'h0000, 3'b000, 13, 0);
    run_op("two",   16'h4000, 16'h3F80, 3'b000, 13, 0);
    run_op("eight", 16'h4100, 16'h4040, 3'b000, 13, 0);
    run_op("half",  16'h3F00, 16'hBF80, 3'b000, 13, 0);
`ifdef FLOG_RNE_EN
    run_op("three", 16'h4040, 16'h3FCB, 3'b001, 13, 0);
`else
    run_op("three", 16'h4040, 16'h3FCA, 3'b001, 13, 0);
`endif
    run_op("pzero", 16'h0000, 16'hFF80, 3'b010, 2, 0);
    run_op("nzero", 16'h8000, 16'hFF80, 3'b010, 2, 0);
    run_op("neg1",  16'hBF80, 16'h7FC0, 3'b100, 2, 0);
    run_op("pinf",  16'h7F80, 16'h7F80, 3'b000, 2, 0);
    run_op("snan",  16'h7F81, 16'h7FC0, 3'b100, 2, 0);
    run_op("qnan",  16'h7FC0, 16'h7FC0, 3'b000, 2, 0);
    run_op("bp",    16'h4000, 16'h3F80, 3'b000, 13, 5);

    // reset in the middle of the iteration
    in_valid_i = 1'b1; op_i = 16'h4040;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1 chk("mid_reset", {30'd0, out_valid_o, in_ready_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    #1 chk("post_reset_rdy", {30'd0, out_valid_o, in_ready_o}, 32'd1);
    run_op("after_rst", 16'h4080, 16'h4000, 3'b000, 13, 0);

    // randomized operands against the model
    for (int i = 0; i < 60; i++) begin
      op = 16'($urandom);
      if (i % 2 == 0) begin
        op[15]   = 1'b0;
        op[14:7] = 8'($urandom_range(1, 254));
      end
      if (i % 6 == 1) begin
        op[15]   = 1'b0;
        op[14:7] = 8'($urandom_range(126, 128));
      end
      ref_log2(op, r, fl, sp);
      run_op($sformatf("rnd%0d_%h", i, op), op, r, fl, sp ? 2 : 13,
             (i % 4 == 3) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
